// File: rtl/rs_encoder_unit_dispatcher.sv
// Round-robin dispatcher feeding whole codeword blocks to a pool of RS encoder units,
// tracking busy units and recording dispatch order for the output side.
module rs_encoder_unit_dispatcher #(
    parameter int NUM_RS_UNITS    = 4,
    parameter int NUM_RS_UNITS_W  = $clog2(NUM_RS_UNITS),
    parameter int LINES_PER_BLOCK = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      src_line_val,
    output logic                      src_line_rdy,
    output logic [NUM_RS_UNITS-1:0]   unit_line_val,
    input  logic [NUM_RS_UNITS-1:0]   unit_line_rdy,
    input  logic                      unit_done_val,
    input  logic [NUM_RS_UNITS_W-1:0] unit_done_id,
    output logic                      ord_val,
    output logic [NUM_RS_UNITS_W-1:0] ord_id,
    input  logic                      ord_rdy,
    output logic [NUM_RS_UNITS-1:0]   units_busy
);

    localparam int CNT_W = $clog2(LINES_PER_BLOCK) + 1;
    localparam int OCC_W = $clog2(NUM_RS_UNITS + 1);
    localparam int MEM_DEPTH = 2 ** NUM_RS_UNITS_W;
    localparam logic [CNT_W-1:0]          LAST_LINE = CNT_W'(LINES_PER_BLOCK - 1);
    localparam logic [NUM_RS_UNITS_W-1:0] LAST_UNIT = NUM_RS_UNITS_W'(NUM_RS_UNITS - 1);
    localparam logic [OCC_W-1:0]          DEPTH     = OCC_W'(NUM_RS_UNITS);

    typedef enum logic {
        FIND,
        STREAM
    } state_t;

    state_t                    state, state_next;
    logic [NUM_RS_UNITS_W-1:0] rr_ptr, rr_ptr_next;
    logic [NUM_RS_UNITS_W-1:0] sel, sel_next;
    logic [CNT_W-1:0]          line_cnt, line_cnt_next;
    logic [NUM_RS_UNITS-1:0]   busy, busy_next;
    logic [NUM_RS_UNITS-1:0]   rr_mask, sel_mask, set_mask, clear_mask;
    logic                      sel_rdy;
    logic                      push, pop;

    logic [NUM_RS_UNITS_W-1:0] fifo_mem [MEM_DEPTH];
    logic [NUM_RS_UNITS_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0]          occ;

    function automatic logic [NUM_RS_UNITS_W-1:0] next_idx(input logic [NUM_RS_UNITS_W-1:0] idx);
        return (idx == LAST_UNIT) ? '0 : idx + 1'b1;
    endfunction

    // Masks avoid direct bit-selects so a widened id port stays well-formed.
    assign rr_mask  = NUM_RS_UNITS'(1) << rr_ptr;
    assign sel_mask = NUM_RS_UNITS'(1) << sel;
    assign sel_rdy  = |(unit_line_rdy & sel_mask);

    always_comb begin
        clear_mask = '0;
        if (unit_done_val && (int'(unit_done_id) < NUM_RS_UNITS)) begin
            clear_mask = (NUM_RS_UNITS'(1) << unit_done_id) & busy;
        end
    end

    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        sel_next      = sel;
        line_cnt_next = line_cnt;
        set_mask      = '0;
        push          = 1'b0;
        unit_line_val = '0;
        src_line_rdy  = 1'b0;
        case (state)
            FIND: begin
                // Strict rotation: wait on rr_ptr even if other units are free.
                if ((busy & rr_mask) == '0) begin
                    sel_next      = rr_ptr;
                    set_mask      = rr_mask;
                    line_cnt_next = '0;
                    state_next    = STREAM;
                end
            end
            STREAM: begin
                unit_line_val = sel_mask & {NUM_RS_UNITS{src_line_val}};
                src_line_rdy  = sel_rdy;
                if (src_line_val && sel_rdy) begin
                    if (line_cnt == LAST_LINE) begin
                        push        = 1'b1;
                        rr_ptr_next = next_idx(rr_ptr);
                        state_next  = FIND;
                    end else begin
                        line_cnt_next = line_cnt + 1'b1;
                    end
                end
            end
            default: state_next = FIND;
        endcase
        busy_next = (busy & ~clear_mask) | set_mask;
    end

    assign pop        = ord_val && ord_rdy;
    assign ord_val    = (occ != '0);
    assign ord_id     = ord_val ? fifo_mem[rd_ptr] : '0;
    assign units_busy = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FIND;
            rr_ptr   <= '0;
            sel      <= '0;
            line_cnt <= '0;
            busy     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_ptr_next;
            sel      <= sel_next;
            line_cnt <= line_cnt_next;
            busy     <= busy_next;
            if (push) begin
                wr_ptr <= next_idx(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_idx(rd_ptr);
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sel;
        end
    end

    order_fifo_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (occ == DEPTH)));

endmodule

// File: tb/tb_rs_encoder_unit_dispatcher.sv
// Directed bench for rs_encoder_unit_dispatcher: a queue scoreboard checks line routing
// and order-queue output while the main sequence drives blocks, done pulses and resets.
module tb_rs_encoder_unit_dispatcher;

    localparam int N = 4;
    localparam int W = 3;   // one spare bit so an out-of-range done id can be driven
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         src_line_val;
    logic         src_line_rdy;
    logic [N-1:0] unit_line_val;
    logic [N-1:0] unit_line_rdy = '0;
    logic         unit_done_val;
    logic [W-1:0] unit_done_id;
    logic         ord_val;
    logic [W-1:0] ord_id;
    logic         ord_rdy;
    logic [N-1:0] units_busy;

    logic [N-1:0] rdy_fixed = '1;
    bit           rand_rdy  = 1'b0;

    int errors = 0;
    int checks = 0;
    int line_q[$];
    int ord_q[$];

    always #5 clk = ~clk;

    rs_encoder_unit_dispatcher #(
        .NUM_RS_UNITS   (N),
        .NUM_RS_UNITS_W (W),
        .LINES_PER_BLOCK(L)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_line_val (src_line_val),
        .src_line_rdy (src_line_rdy),
        .unit_line_val(unit_line_val),
        .unit_line_rdy(unit_line_rdy),
        .unit_done_val(unit_done_val),
        .unit_done_id (unit_done_id),
        .ord_val      (ord_val),
        .ord_id       (ord_id),
        .ord_rdy      (ord_rdy),
        .units_busy   (units_busy)
    );

    always @(posedge clk) begin
        #1;
        unit_line_rdy = rand_rdy ? N'($urandom) : rdy_fixed;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops the expected unit per line handshake and the expected id per order pop.
    task automatic monitor_loop();
        logic [N-1:0] hs;
        int           got;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hs = unit_line_val & unit_line_rdy;
                if (unit_line_val != '0 && !src_line_val)
                    chk("spurious_unit_line_val", int'(unit_line_val), 0);
                if ($countones(unit_line_val) > 1)
                    chk("unit_line_val_onehot", $countones(unit_line_val), 1);
                if (src_line_val && (src_line_rdy != (hs != '0)))
                    chk("src_line_rdy_passthru", int'(src_line_rdy), int'(hs != '0));
                if (hs != '0) begin
                    got = -1;
                    for (int i = 0; i < N; i++) if (hs[i]) got = i;
                    if (line_q.size() == 0) chk("unexpected_line_unit", got, -1);
                    else chk("line_unit", got, line_q.pop_front());
                end
                if (ord_val && ord_rdy) begin
                    if (ord_q.size() == 0) chk("unexpected_ord_pop", int'(ord_id), -1);
                    else chk("ord_id", int'(ord_id), ord_q.pop_front());
                end
            end
        end
    endtask

    task automatic send_lines(input int unit, input int n, input bit complete,
                              input bit pop_last, input int gap);
        bit ok;
        for (int k = 0; k < n; k++) begin
            src_line_val = 1'b0;
            for (int g = 0; g < gap; g++) tick();
            line_q.push_back(unit);
            src_line_val = 1'b1;
            if (pop_last && k == n - 1) ord_rdy = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(negedge clk);
                ok = src_line_rdy;
                tick();
            end
            ord_rdy = 1'b0;
            if (!ok) chk("line_handshake_timeout", 0, 1);
        end
        src_line_val = 1'b0;
        if (complete) ord_q.push_back(unit);
    endtask

    task automatic done_pulse(input int id);
        unit_done_val = 1'b1;
        unit_done_id  = W'(id);
        tick();
        unit_done_val = 1'b0;
        unit_done_id  = '0;
    endtask

    task automatic pop_ord(input int n);
        ord_rdy = 1'b1;
        for (int i = 0; i < n; i++) tick();
        ord_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        src_line_val = 1'b0;
        unit_done_val = 1'b0;
        unit_done_id = '0;
        ord_rdy = 1'b0;
        fork
            monitor_loop();
        join_none
        repeat (3) tick();
        chk("rst_src_line_rdy", int'(src_line_rdy), 0);
        chk("rst_unit_line_val", int'(unit_line_val), 0);
        chk("rst_ord_val", int'(ord_val), 0);
        chk("rst_ord_id", int'(ord_id), 0);
        chk("rst_units_busy", int'(units_busy), 0);
        rst = 1'b0;

        // Two blocks, all ready: units 0 and 1.
        send_lines(0, L, 1, 0, 0);
        send_lines(1, L, 1, 0, 0);
        chk("busy_after_2_blocks", int'(units_busy), 'b0011);
        chk("ord_val_after_2_blocks", int'(ord_val), 1);
        pop_ord(2);
        chk("ord_empty_after_pops", int'(ord_val), 0);

        // Fill units 2,3; fifth block stalls until unit 0 is drained.
        send_lines(2, L, 1, 0, 0);
        send_lines(3, L, 1, 0, 0);
        chk("busy_all_full", int'(units_busy), 'b1111);
        fork
            send_lines(0, L, 1, 0, 0);
            begin
                repeat (3) tick();
                chk("stall_src_line_rdy", int'(src_line_rdy), 0);
                chk("stall_unit_line_val", int'(unit_line_val), 0);
                chk("stall_units_busy", int'(units_busy), 'b1111);
                done_pulse(0);
                chk("done0_busy_cleared", int'(units_busy), 'b1110);
                chk("done0_not_yet_dispatched", int'(unit_line_val), 0);
                tick();
                chk("done0_dispatched", int'(unit_line_val), 'b0001);
                chk("done0_busy_reset", int'(units_busy), 'b1111);
            end
        join

        // Out-of-range and non-busy done ids are ignored.
        done_pulse(5);
        chk("done_id5_ignored", int'(units_busy), 'b1111);
        done_pulse(1);
        chk("done1_cleared", int'(units_busy), 'b1101);
        tick();
        done_pulse(2);
        chk("done2_cleared", int'(units_busy), 'b1011);
        done_pulse(2);
        chk("done_nonbusy_ignored", int'(units_busy), 'b1011);
        done_pulse(3);
        chk("done3_cleared", int'(units_busy), 'b0011);

        // Pop coinciding with push while one entry is queued.
        pop_ord(2);
        chk("one_entry_val", int'(ord_val), 1);
        chk("one_entry_head", int'(ord_id), 0);
        send_lines(1, L, 1, 1, 0);
        chk("push_pop_val", int'(ord_val), 1);
        chk("push_pop_head", int'(ord_id), 1);
        pop_ord(1);
        chk("push_pop_occupancy_one", int'(ord_val), 0);

        // Random unit readiness and gapped source valid.
        rand_rdy = 1'b1;
        send_lines(2, L, 1, 0, 2);
        send_lines(3, L, 1, 0, 1);
        rand_rdy = 1'b0;
        repeat (2) tick();
        chk("random_lines_outstanding", line_q.size(), 0);

        // Mid-block reset into unit 2.
        pop_ord(2);
        done_pulse(0);
        done_pulse(1);
        done_pulse(2);
        done_pulse(3);
        chk("all_freed_busy", int'(units_busy), 'b0001);
        send_lines(0, L, 1, 0, 0);
        send_lines(1, L, 1, 0, 0);
        send_lines(2, 2, 0, 0, 0);
        rst = 1'b1;
        tick();
        chk("midrst_src_line_rdy", int'(src_line_rdy), 0);
        chk("midrst_unit_line_val", int'(unit_line_val), 0);
        chk("midrst_ord_val", int'(ord_val), 0);
        chk("midrst_ord_id", int'(ord_id), 0);
        chk("midrst_units_busy", int'(units_busy), 0);
        ord_q.delete();
        rst = 1'b0;
        tick();
        send_lines(0, L, 1, 0, 0);
        chk("after_rst_busy", int'(units_busy), 'b0001);
        pop_ord(1);
        chk("after_rst_ord_empty", int'(ord_val), 0);

        repeat (3) tick();
        chk("lines_left_in_scoreboard", line_q.size(), 0);
        chk("ords_left_in_scoreboard", ord_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_encoder_unit_dispatcher.md
RS_ENCODER_UNIT_DISPATCHER -- requirements
Module: rs_encoder_unit_dispatcher

Interface
REQ-001 SHALL have parameter NUM_RS_UNITS, default 4, the number of RS encoder units shared (legal 2..16).
REQ-002 SHALL have parameter NUM_RS_UNITS_W, default $clog2(NUM_RS_UNITS), the unit-index width.
REQ-003 SHALL have parameter LINES_PER_BLOCK, default 4, the number of data lines per codeword block (legal 1..256).
REQ-004 SHALL have port clk  input  1  clock; reset rst, synchronous, active-high.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port src_line_val  input  1  source data line valid.
REQ-007 SHALL have port src_line_rdy  output  1  dispatcher accepts the source line.
REQ-008 SHALL have port unit_line_val  output  NUM_RS_UNITS  one-hot line valid to each encoder unit.
REQ-009 SHALL have port unit_line_rdy  input  NUM_RS_UNITS  per-unit line ready.
REQ-010 SHALL have port unit_done_val  input  1  output side has fully drained one unit.
REQ-011 SHALL have port unit_done_id  input  NUM_RS_UNITS_W  index of the drained unit.
REQ-012 SHALL have port ord_val  output  1  order queue non-empty.
REQ-013 SHALL have port ord_id  output  NUM_RS_UNITS_W  oldest dispatched unit index.
REQ-014 SHALL have port ord_rdy  input  1  output side pops the order queue.
REQ-015 SHALL have port units_busy  output  NUM_RS_UNITS  per-unit busy flags.

Function
REQ-016 SHALL implement states FIND and STREAM; all state, counters and flags are registers updated on posedge clk.
REQ-017 SHALL hold rr_ptr (NUM_RS_UNITS_W bits), sel (NUM_RS_UNITS_W bits), line_cnt ($clog2(LINES_PER_BLOCK)+1 bits), busy (NUM_RS_UNITS bits), and an order FIFO of depth NUM_RS_UNITS.
REQ-018 FIND: src_line_rdy=0, unit_line_val=0; if busy[rr_ptr]=0 and not being set this cycle, sel<=rr_ptr, busy[rr_ptr]<=1, line_cnt<=0, next STREAM; else remain FIND (strict rotation, no skipping).
REQ-019 STREAM: unit_line_val[sel]=src_line_val, all other bits 0; src_line_rdy=unit_line_rdy[sel] (combinational, zero-cycle pass-through).
REQ-020 STREAM handshake (src_line_val & src_line_rdy) SHALL increment line_cnt; when line_cnt==LINES_PER_BLOCK-1 it SHALL instead push sel into the order FIFO, advance rr_ptr (wrap NUM_RS_UNITS-1 -> 0), next FIND.
REQ-021 STREAM without handshake SHALL hold all state; src_line_val may drop mid-block.
REQ-022 unit_done_val=1 SHALL clear busy[unit_done_id] next cycle; ids >= NUM_RS_UNITS or of non-busy units SHALL be ignored.
REQ-023 Done-clear of unit rr_ptr in FIND SHALL take effect next cycle; dispatch to that unit no earlier than the following cycle.
REQ-024 ord_val=FIFO non-empty, ord_id=FIFO head; pop on ord_val & ord_rdy; simultaneous push and pop SHALL both occur, occupancy unchanged; pop when empty ignored.
REQ-025 FIFO SHALL never overflow (entries <= busy units <= NUM_RS_UNITS); a push while full SHALL be flagged by a simulation assertion.
REQ-026 units_busy SHALL equal the busy register.
REQ-027 Blocks SHALL be dispatched in strict order 0,1,...,NUM_RS_UNITS-1,0,...; ord_id sequence SHALL match dispatch order.

Reset
REQ-028 On rst: state FIND, rr_ptr=0, sel=0, line_cnt=0, busy=0, FIFO empty; src_line_rdy=0, unit_line_val=0, ord_val=0, ord_id=0, units_busy=0.
REQ-029 rst asserted mid-block SHALL discard the partial block and all queued order entries, with no further unit_line_val pulses.

Verification
REQ-030 Reset, then 2 blocks (N=4, L=4), all ready high -> lines 0-3 to unit 0, 4-7 to unit 1; ord_id 0 then 1; units_busy=4'b0011.
REQ-031 5 blocks with no unit_done -> units 0-3 filled, 5th block stalls: FIND, src_line_rdy=0; unit_done_id=0 -> 5th block dispatched to unit 0 two cycles later.
REQ-032 unit_line_rdy[sel] toggled randomly, src_line_val gapped -> every line delivered exactly once, in order, only to unit sel.
REQ-033 ord_rdy pulsed in the same cycle as a push with 1 entry queued -> occupancy stays 1, head advances to new id.
REQ-034 rst asserted after 2 of 4 lines into unit 2 -> next cycle all outputs at reset values; fresh block goes to unit 0.
REQ-035 unit_done_val with id 5 (N=4) or a non-busy unit -> busy unchanged.
